// File: rtl/crack_job_dispatcher.sv
// Splits one password-cracking job across LANES cracker lanes by digit3 range and
// reports the first lane that finds it, or that all lanes are exhausted.
module crack_job_dispatcher #(
    parameter int unsigned LANES = 4,
    parameter int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 pwd_valid_i,
    output logic                 pwd_ready_o,
    input  logic [31:0]          pwd_data_i,
    output logic [LANES-1:0]     lane_rst_o,
    output logic [31:0]          lane_pwd_o,
    output logic [LANES*6-1:0]   lane_from_o,
    output logic [LANES*6-1:0]   lane_to_o,
    input  logic [LANES-1:0]     lane_found_i,
    input  logic [LANES-1:0]     lane_done_i,
    output logic                 result_valid_o,
    input  logic                 result_ready_i,
    output logic                 result_found_o,
    output logic                 result_err_o,
    output logic [LW-1:0]        result_lane_o,
    output logic [31:0]          result_cycles_o
);

    localparam int unsigned NDIG = 36;
    localparam int unsigned S    = (NDIG + LANES - 1) / LANES;

    if (LANES < 1 || LANES > NDIG) begin : g_bad_lanes
        $error("crack_job_dispatcher: LANES must be in 1..36");
    end

    typedef enum logic [2:0] {IDLE, CHECK, LRST, RUN, REPORT} state_e;

    state_e             state_q, state_d;
    logic               pwd_ready_q, pwd_ready_d;
    logic [LANES-1:0]   lane_rst_q, lane_rst_d;
    logic [31:0]        pwd_q, pwd_d;
    logic               lrst_cnt_q, lrst_cnt_d;
    logic [31:0]        cnt_q, cnt_d;
    logic               res_valid_q, res_valid_d;
    logic               res_found_q, res_found_d;
    logic               res_err_q, res_err_d;
    logic [LW-1:0]      res_lane_q, res_lane_d;
    logic [31:0]        res_cycles_q, res_cycles_d;

    logic [LANES-1:0]   used;
    logic               pwd_legal;
    logic               found_any;
    logic               all_done;
    logic [LW-1:0]      found_idx;
    logic [31:0]        cnt_inc;

    // Static digit3 range per lane; lanes starting past digit 35 stay parked in reset.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        localparam int unsigned FROM   = g * S;
        localparam int unsigned TO_RAW = (g + 1) * S - 1;
        localparam int unsigned TO     = (TO_RAW > NDIG - 1) ? NDIG - 1 : TO_RAW;
        localparam bit          USED   = (FROM < NDIG);
        assign lane_from_o[6*g +: 6] = USED ? 6'(FROM) : 6'(NDIG - 1);
        assign lane_to_o[6*g +: 6]   = 6'(TO);
        assign used[g]               = USED;
    end

    always_comb begin
        pwd_legal = 1'b1;
        for (int b = 0; b < 4; b++) begin
            if (pwd_q[8*b +: 8] < 8'h30 || pwd_q[8*b +: 8] > 8'h53) pwd_legal = 1'b0;
        end
    end

    // Lowest found lane wins; unused lanes count as done and never as found.
    always_comb begin
        found_idx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_found_i[i] && used[i]) found_idx = LW'(i);
        end
    end

    assign found_any = |(lane_found_i & used);
    assign all_done  = &(lane_done_i | ~used);
    assign cnt_inc   = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;

    always_comb begin
        state_d      = state_q;
        pwd_ready_d  = pwd_ready_q;
        lane_rst_d   = lane_rst_q;
        pwd_d        = pwd_q;
        lrst_cnt_d   = lrst_cnt_q;
        cnt_d        = cnt_q;
        res_valid_d  = res_valid_q;
        res_found_d  = res_found_q;
        res_err_d    = res_err_q;
        res_lane_d   = res_lane_q;
        res_cycles_d = res_cycles_q;
        case (state_q)
            IDLE: begin
                pwd_ready_d = 1'b1;
                lane_rst_d  = '1;
                if (pwd_valid_i && pwd_ready_q) begin
                    pwd_d       = pwd_data_i;
                    pwd_ready_d = 1'b0;
                    state_d     = CHECK;
                end
            end
            CHECK: begin
                if (!pwd_legal) begin
                    state_d      = REPORT;
                    res_valid_d  = 1'b1;
                    res_err_d    = 1'b1;
                    res_found_d  = 1'b0;
                    res_lane_d   = '0;
                    res_cycles_d = '0;
                end else begin
                    state_d    = LRST;
                    lrst_cnt_d = 1'b0;
                end
            end
            LRST: begin
                if (lrst_cnt_q) begin
                    state_d    = RUN;
                    lane_rst_d = ~used;
                    cnt_d      = '0;
                end else begin
                    lrst_cnt_d = 1'b1;
                end
            end
            RUN: begin
                cnt_d = cnt_inc;
                if (found_any || all_done) begin
                    state_d      = REPORT;
                    lane_rst_d   = '1;
                    res_valid_d  = 1'b1;
                    res_err_d    = 1'b0;
                    res_found_d  = found_any;
                    res_lane_d   = found_any ? found_idx : '0;
                    res_cycles_d = cnt_inc;
                end
            end
            REPORT: begin
                if (result_ready_i) begin
                    state_d     = IDLE;
                    res_valid_d = 1'b0;
                    pwd_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            pwd_ready_q  <= 1'b0;
            lane_rst_q   <= '1;
            pwd_q        <= '0;
            lrst_cnt_q   <= 1'b0;
            cnt_q        <= '0;
            res_valid_q  <= 1'b0;
            res_found_q  <= 1'b0;
            res_err_q    <= 1'b0;
            res_lane_q   <= '0;
            res_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            pwd_ready_q  <= pwd_ready_d;
            lane_rst_q   <= lane_rst_d;
            pwd_q        <= pwd_d;
            lrst_cnt_q   <= lrst_cnt_d;
            cnt_q        <= cnt_d;
            res_valid_q  <= res_valid_d;
            res_found_q  <= res_found_d;
            res_err_q    <= res_err_d;
            res_lane_q   <= res_lane_d;
            res_cycles_q <= res_cycles_d;
        end
    end

    assign pwd_ready_o     = pwd_ready_q;
    assign lane_rst_o      = lane_rst_q;
    assign lane_pwd_o      = pwd_q;
    assign result_valid_o  = res_valid_q;
    assign result_found_o  = res_found_q;
    assign result_err_o    = res_err_q;
    assign result_lane_o   = res_lane_q;
    assign result_cycles_o = res_cycles_q;

endmodule

// File: tb/tb_crack_job_dispatcher.sv
// Directed bench for crack_job_dispatcher: LANES=4 functional checks plus LANES=5 range split.
module tb_crack_job_dispatcher;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pwd_valid;
    logic        pwd_ready;
    logic [31:0] pwd_data;
    logic [3:0]  lane_rst;
    logic [31:0] lane_pwd;
    logic [23:0] lane_from, lane_to;
    logic [3:0]  lane_found, lane_done;
    logic        result_valid, result_ready, result_found, result_err;
    logic [1:0]  result_lane;
    logic [31:0] result_cycles;

    logic        pwd_ready5;
    logic [4:0]  lane_rst5;
    logic [31:0] lane_pwd5;
    logic [29:0] lane_from5, lane_to5;
    logic        result_valid5, result_found5, result_err5;
    logic [2:0]  result_lane5;
    logic [31:0] result_cycles5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    crack_job_dispatcher #(.LANES(4)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .pwd_valid_i(pwd_valid), .pwd_ready_o(pwd_ready), .pwd_data_i(pwd_data),
        .lane_rst_o(lane_rst), .lane_pwd_o(lane_pwd),
        .lane_from_o(lane_from), .lane_to_o(lane_to),
        .lane_found_i(lane_found), .lane_done_i(lane_done),
        .result_valid_o(result_valid), .result_ready_i(result_ready),
        .result_found_o(result_found), .result_err_o(result_err),
        .result_lane_o(result_lane), .result_cycles_o(result_cycles)
    );

    crack_job_dispatcher #(.LANES(5)) dut5 (
        .clk_i(clk), .rst_ni(rst_n),
        .pwd_valid_i(1'b0), .pwd_ready_o(pwd_ready5), .pwd_data_i(32'h0),
        .lane_rst_o(lane_rst5), .lane_pwd_o(lane_pwd5),
        .lane_from_o(lane_from5), .lane_to_o(lane_to5),
        .lane_found_i(5'b0), .lane_done_i(5'b0),
        .result_valid_o(result_valid5), .result_ready_i(1'b0),
        .result_found_o(result_found5), .result_err_o(result_err5),
        .result_lane_o(result_lane5), .result_cycles_o(result_cycles5)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Present a job and return at the negedge of the CHECK cycle.
    task automatic send_job(input logic [31:0] data);
        int waited = 0;
        pwd_valid = 1'b1;
        pwd_data  = data;
        while (pwd_ready !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        chk("accept_timeout", 64'(waited < 10), 64'd1);
        tick();
        pwd_valid = 1'b0;
        chk("check_not_ready", 64'(pwd_ready), 64'd0);
        chk("lane_pwd", 64'(lane_pwd), 64'(data));
    endtask

    // Legal job through both LRST cycles; returns at the negedge of RUN cycle 1.
    task automatic start_run(input logic [31:0] data);
        send_job(data);
        chk("check_rst", 64'(lane_rst), 64'hF);
        tick();
        chk("lrst1", 64'(lane_rst), 64'hF);
        tick();
        chk("lrst2", 64'(lane_rst), 64'hF);
        tick();
        chk("run_entry_rst", 64'(lane_rst), 64'h0);
    endtask

    // Drive found/done during RUN cycle k (counted from the current cycle as 1).
    task automatic exit_at(input int k, input logic [3:0] f, input logic [3:0] d);
        repeat (k - 1) tick();
        lane_found = f;
        lane_done  = d;
        tick();
        lane_found = '0;
        lane_done  = '0;
    endtask

    task automatic expect_result(input string tag, input logic found, input logic err,
                                 input logic [1:0] lane, input logic [31:0] cycles);
        chk({tag, "_valid"}, 64'(result_valid), 64'd1);
        chk({tag, "_fields"}, {29'(0), result_found, result_err, result_lane, result_cycles},
            {29'(0), found, err, lane, cycles});
        chk({tag, "_lane_rst"}, 64'(lane_rst), 64'hF);
        chk({tag, "_no_ready"}, 64'(pwd_ready), 64'd0);
    endtask

    task automatic ack();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        chk("ack_valid", 64'(result_valid), 64'd0);
        chk("ack_ready", 64'(pwd_ready), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; pwd_valid = 1'b0; pwd_data = '0;
        lane_found = '0; lane_done = '0; result_ready = 1'b0;
        @(negedge clk);
        chk("rst_ready", 64'(pwd_ready), 64'd0);
        chk("rst_lane_rst", 64'(lane_rst), 64'hF);
        chk("rst_results", {result_valid, result_found, result_err, result_lane, result_cycles, lane_pwd}, 64'd0);
        chk("from4", 64'(lane_from), {40'd0, 6'd27, 6'd18, 6'd9, 6'd0});
        chk("to4", 64'(lane_to), {40'd0, 6'd35, 6'd26, 6'd17, 6'd8});
        chk("from5", 64'(lane_from5), {34'd0, 6'd32, 6'd24, 6'd16, 6'd8, 6'd0});
        chk("to5", 64'(lane_to5), {34'd0, 6'd35, 6'd31, 6'd23, 6'd15, 6'd7});
        chk("rst5_lane_rst", 64'(lane_rst5), 64'h1F);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 64'(pwd_ready), 64'd1);
        chk("post_rst_ready5", 64'(pwd_ready5), 64'd1);
        chk("idle5", {result_valid5, result_found5, result_err5, result_lane5, result_cycles5, lane_pwd5}, 64'd0);

        // "0000": lane 0 finds it in RUN cycle 5
        start_run(32'h3030_3030);
        exit_at(5, 4'b0001, 4'b0000);
        expect_result("job0000", 1'b1, 1'b0, 2'd0, 32'd5);
        // Result holds while unacknowledged; new requests are ignored
        pwd_valid = 1'b1;
        pwd_data  = 32'h3131_3131;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("hold_fields", {result_valid, result_found, result_err, result_lane, result_cycles},
                {1'b1, 1'b1, 1'b0, 2'd0, 32'd5});
            chk("hold_ready", 64'(pwd_ready), 64'd0);
        end
        chk("hold_pwd", 64'(lane_pwd), 64'h3030_3030);
        pwd_valid = 1'b0;
        ack();

        // Lanes 1 and 3 found together -> lowest index
        start_run(32'h3930_3030);
        exit_at(3, 4'b1010, 4'b0000);
        expect_result("tie13", 1'b1, 1'b0, 2'd1, 32'd3);
        ack();

        // All done, nothing found, at RUN cycle 100
        start_run(32'h3131_3131);
        exit_at(100, 4'b0000, 4'b1111);
        expect_result("alldone", 1'b0, 1'b0, 2'd0, 32'd100);
        ack();

        // Found and all-done in the same cycle -> found wins
        start_run(32'h3232_3232);
        exit_at(7, 4'b0100, 4'b1111);
        expect_result("found_wins", 1'b1, 1'b0, 2'd2, 32'd7);
        ack();

        // Partial done does not end the job
        start_run(32'h4141_4141);
        exit_at(2, 4'b0000, 4'b0111);
        chk("partial_running", 64'(result_valid), 64'd0);
        chk("partial_lane_rst", 64'(lane_rst), 64'h0);
        exit_at(2, 4'b0000, 4'b1111);
        expect_result("late_done", 1'b0, 1'b0, 2'd0, 32'd4);
        ack();

        // Illegal byte 0x2F -> error one cycle after accept, lanes never released
        send_job(32'h302F_3030);
        chk("err_check_valid", 64'(result_valid), 64'd0);
        tick();
        expect_result("err2f", 1'b0, 1'b1, 2'd0, 32'd0);
        ack();

        // Upper edge: 0x54 illegal, 0x53 legal
        send_job(32'h3030_5430);
        tick();
        expect_result("err54", 1'b0, 1'b1, 2'd0, 32'd0);
        ack();
        start_run(32'h5330_3030);
        exit_at(1, 4'b1000, 4'b0000);
        expect_result("legal53", 1'b1, 1'b0, 2'd3, 32'd1);
        ack();

        // Reset mid-RUN aborts the job
        start_run(32'h3535_3535);
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_lane_rst", 64'(lane_rst), 64'hF);
        chk("midrst_valid", 64'(result_valid), 64'd0);
        chk("midrst_ready", 64'(pwd_ready), 64'd0);
        lane_found = 4'b0001;
        @(negedge clk);
        rst_n = 1'b1;
        lane_found = '0;
        tick();
        chk("after_rst_valid", 64'(result_valid), 64'd0);
        chk("after_rst_cycles", 64'(result_cycles), 64'd0);
        chk("after_rst_ready", 64'(pwd_ready), 64'd1);
        start_run(32'h3636_3636);
        exit_at(2, 4'b0010, 4'b0000);
        expect_result("clean_job", 1'b1, 1'b0, 2'd1, 32'd2);
        ack();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crack_job_dispatcher.md
CRACK_JOB_DISPATCHER -- requirements
Module: crack_job_dispatcher

Interface
REQ-001 Parameter LANES, default 4, meaning number of password_cracker lanes driven (legal 1..36).
REQ-002 Parameter LW, default $clog2(LANES) (min 1), meaning width of result_lane.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 pwd_valid  in  1  job request; pwd_data stable while high.
REQ-006 pwd_ready  out  1  dispatcher accepts job this cycle.
REQ-007 pwd_data  in  32  ASCII password; byte[7:0]=digit0 ... byte[31:24]=digit3.
REQ-008 lane_rst  out  LANES  active-high reset per cracker lane.
REQ-009 lane_pwd  out  32  registered copy of accepted pwd_data, shared by all lanes.
REQ-010 lane_from / lane_to  out  LANES*6 each  per-lane inclusive digit3 range, lane i at bits [6i+5:6i].
REQ-011 lane_found / lane_done  in  LANES each  per-lane status from crackers.
REQ-012 result_valid  out 1; result_ready  in 1  result handshake.
REQ-013 result_found out 1, result_err out 1, result_lane out LW, result_cycles out 32  job outcome.

Function
REQ-014 FSM states: IDLE, CHECK, LRST, RUN, REPORT; reset state IDLE.
REQ-015 IDLE: pwd_ready=1, lane_rst all ones; pwd_valid&&pwd_ready latches pwd_data into lane_pwd, goes to CHECK.
REQ-016 CHECK (1 cycle): each byte legal iff 0x30..0x53 (value-48 in 0..35); any illegal -> REPORT with result_err=1, result_found=0, result_lane=0, result_cycles=0; else -> LRST.
REQ-017 Range split: S=ceil(36/LANES); lane i from=i*S, to=min((i+1)*S-1,35); LANES=4 gives 0-8, 9-17, 18-26, 27-35.
REQ-018 Lane with i*S>35 is unused: lane_rst held 1 forever, its lane_done/lane_found ignored, treated as done.
REQ-019 lane_from/lane_to are constants derived from parameters, valid in all states including reset.
REQ-020 LRST: lane_rst all ones for exactly 2 cycles, then -> RUN; lane_rst of used lanes deasserts on RUN entry.
REQ-021 RUN: cycle counter cleared on RUN entry, +1 per RUN cycle, saturates at 0xFFFFFFFF.
REQ-022 RUN exit on any used lane_found=1: result_found=1, result_lane=lowest such index -> REPORT.
REQ-023 RUN exit when all used lane_done=1 and no lane_found: result_found=0, result_lane=0 -> REPORT.
REQ-024 Found and all-done in same cycle: found wins.
REQ-025 On RUN exit all lane_rst reassert next cycle; result_cycles = counter value at exit cycle.
REQ-026 REPORT: result_valid=1, result fields stable; result_valid&&result_ready -> IDLE next cycle; pwd_ready=0 outside IDLE.
REQ-027 pwd_valid outside IDLE is ignored (no buffering); requester holds it until pwd_ready.

Reset
REQ-028 rst low asynchronously forces: state IDLE, pwd_ready=0 while rst low then 1, lane_rst all ones, lane_pwd=0, result_valid=0, result_found=0, result_err=0, result_lane=0, result_cycles=0, counter=0.
REQ-029 Reset mid-RUN/REPORT aborts job; no result produced; first post-reset job starts clean.

Verification
REQ-030 LANES=4, pwd_data=0x30303030 ("0000"), lane 0 model found after 5 RUN cycles -> result_found=1, result_lane=0, result_cycles=5.
REQ-031 pwd_data with byte[31:24]=0x39, lanes 1 and 3 report found same cycle -> result_lane=1.
REQ-032 pwd_data=0x302F3030 (illegal 0x2F) -> REPORT 1 cycle after accept, result_err=1, lane_rst never deasserts.
REQ-033 All four lane models assert done, none found, at RUN cycle 100 -> result_found=0, result_cycles=100; lane 2 found with all done same cycle -> found=1, lane=2.
REQ-034 LANES=5 (S=8): lane_from/to = 0-7, 8-15, 16-23, 24-31, 32-35; LANES=37 rejected (out of legal range).
REQ-035 rst pulsed low mid-RUN -> all lane_rst=1 immediately, result_valid stays 0; hold result_ready=0 in REPORT 10 cycles -> result fields unchanged, pwd_ready=0.
